ram_w: RTL and testbench
========================

Name: ram_w

Overview:
- Avalon-MM burst write master: the write-direction counterpart of the burst read master.
- Client logic pushes words into an internal show-ahead FIFO. The block drains them to RAM as fixed-length bursts of MAX_BURST_COUNT_W beats, starting at a programmed base address.
- Sits between the Sobel output pixel stream and the SDRAM controller's write port.

Parameters:
- DATA_WIDTH, 32, data bus and counter width
- ADD_WIDTH, 32, byte address width
- BYTE_ENABLE_WIDTH, 4, bytes per word
- MAX_BURST_COUNT_W, 32, beats per burst
- BURST_WIDTH_W, 6, width of ram_w_burstcount
- FIFO_DEPTH_LOG2, 8, log2 of FIFO depth
- FIFO_DEPTH, 256, FIFO words

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- ram_w_address  out  ADD_WIDTH  burst base byte address
- ram_w_waitrequest  in  1  slave stall
- ram_w_byteenable  out  BYTE_ENABLE_WIDTH  always all ones
- ram_w_write  out  1  write request
- ram_w_writedata  out  DATA_WIDTH  FIFO head word
- ram_w_burstcount  out  BURST_WIDTH_W  constant MAX_BURST_COUNT_W
- data_fifo_out  in  DATA_WIDTH  client write data
- write_fifo_out  in  1  client push strobe
- start_fifo_out  in  1  synchronous start/abort pulse
- address_fifo_out  in  ADD_WIDTH  base address, sampled on start
- n_burst_fifo_out  in  DATA_WIDTH  number of bursts, sampled on start
- bussy_fifo_out  out  1  transfer in progress
- full_fifo_out  out  1  FIFO full
- usedw_fifo_out  out  FIFO_DEPTH_LOG2+1  FIFO fill level

Behaviour:
- Reset (rst low), asynchronous:
  - FSM goes to IDLE; all counters are 0; FIFO is cleared.
  - ram_w_write=0, bussy_fifo_out=0, ram_w_address=0, full_fifo_out=0, usedw_fifo_out=0.
  - A reset mid-burst drops write immediately. This is allowed only together with a system reset.
- start_fifo_out=1, in any state, takes priority over every other event:
  - clears the FIFO; a push in the same cycle is discarded;
  - loads addr_r from address_fifo_out, bursts_left from n_burst_fifo_out, beats_left from 0;
  - FSM goes to WAIT_DATA, or to IDLE if n_burst_fifo_out=0;
  - aborts any burst in progress.
- FSM states:
  - IDLE: write=0. Leaves only on start.
  - WAIT_DATA: write=0. Goes to BURST on the next edge once usedw >= MAX_BURST_COUNT_W and bursts_left != 0. beats_left is loaded with MAX_BURST_COUNT_W on that transition.
  - BURST: write=1, address=addr_r, writedata=FIFO head (show-ahead, zero latency).
    - Each cycle with write & !waitrequest is one accepted beat: the FIFO is popped in that same cycle and beats_left is decremented.
    - On the final beat (beats_left=1 and accepted): addr_r += MAX_BURST_COUNT_W*BYTE_ENABLE_WIDTH (modulo 2^ADD_WIDTH) and bursts_left -= 1. FSM goes to WAIT_DATA if bursts_left becomes non-zero, else to IDLE.
- Data is always complete before a burst starts, so write stays high for the whole burst with no bubbles. address and burstcount stay stable for the whole burst.
- bussy_fifo_out = (bursts_left != 0) | (state == BURST). It falls in the cycle after the last beat is accepted.
- A push while full_fifo_out=1 is dropped; FIFO contents and count are unchanged.
- Simultaneous push and pop: usedw is unchanged.
- Words pushed beyond n_burst*MAX_BURST_COUNT_W stay in the FIFO until the next start.
- usedw_fifo_out is the full count including bit FIFO_DEPTH_LOG2, so it reads FIFO_DEPTH when full.

Optional Feature:
- Macro RAM_W_STALL_CNT_EN.
- Defined:
  - adds output stall_cnt_fifo_out, width DATA_WIDTH;
  - counts cycles with ram_w_write & ram_w_waitrequest, saturating at all ones;
  - cleared by reset and by start.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ram_if_pkg holds:
  - FSM state encoding (IDLE, WAIT_DATA, BURST);
  - default burst and FIFO constants, shared with ram_r.
- One sub-module, ram_w_fifo: synchronous show-ahead FIFO with sync clear, full flag and a FIFO_DEPTH_LOG2+1-bit count.

Test Plan:
- Single burst, no stall: start with address=0x1000, n_burst=1, push 32 words 0..31, waitrequest=0.
  - write rises one cycle after usedw reaches 32 and stays high exactly 32 cycles.
  - address=0x1000, burstcount=32, data 0..31 in order.
  - bussy_fifo_out falls the cycle after the last beat.
- Stall mid-burst: n_burst=2, waitrequest high on beats 5-7.
  - writedata and address hold during the stall.
  - Second burst address is 0x1080; 64 beats total.
- Overflow: push 260 words with waitrequest=1 and n_burst=0.
  - full_fifo_out=1 and usedw_fifo_out=256; the last 4 words are lost.
- Abort: start during beat 10 of a burst, with new address 0x2000 and n_burst=1.
  - write drops the next cycle and the FIFO is empty.
  - The next burst uses 0x2000.
- Zero bursts: start with n_burst=0 -> bussy_fifo_out stays 0 and write is never asserted.
- Async reset mid-burst: rst low during beat 3 -> write=0 and bussy_fifo_out=0 immediately, with no clock edge needed. Under RAM_W_STALL_CNT_EN, stall_cnt_fifo_out=0.

Source files
------------

// File: rtl/ram_if_pkg.sv
// Shared definitions for the Avalon-MM burst RAM masters (ram_r / ram_w):
// FSM state encoding and default burst / FIFO sizing.
package ram_if_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2
    } ram_state_t;

    localparam int RAM_DATA_WIDTH      = 32;
    localparam int RAM_ADD_WIDTH       = 32;
    localparam int RAM_BYTE_EN_WIDTH   = 4;
    localparam int RAM_BURST_COUNT     = 32;
    localparam int RAM_BURST_WIDTH     = 6;
    localparam int RAM_FIFO_DEPTH_LOG2 = 8;
    localparam int RAM_FIFO_DEPTH      = 1 << RAM_FIFO_DEPTH_LOG2;

endpackage

// File: rtl/ram_w_fifo.sv
// Synchronous show-ahead FIFO: rdata always shows the head word, clear is
// synchronous and wins over push/pop, pushes while full are dropped.
module ram_w_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   usedw
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_CNT);
    assign usedw   = count;
    assign rdata   = mem[rd_ptr];
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & (count != '0) & ~clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ram_w.sv
// Avalon-MM burst write master: drains an internal FIFO to RAM in fixed bursts.
// Optional macro RAM_W_STALL_CNT_EN adds a saturating waitrequest stall counter.
module ram_w
    import ram_if_pkg::*;
#(
    parameter int DATA_WIDTH        = RAM_DATA_WIDTH,
    parameter int ADD_WIDTH         = RAM_ADD_WIDTH,
    parameter int BYTE_ENABLE_WIDTH = RAM_BYTE_EN_WIDTH,
    parameter int MAX_BURST_COUNT_W = RAM_BURST_COUNT,
    parameter int BURST_WIDTH_W     = RAM_BURST_WIDTH,
    parameter int FIFO_DEPTH_LOG2   = RAM_FIFO_DEPTH_LOG2,
    parameter int FIFO_DEPTH        = RAM_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [ADD_WIDTH-1:0]          ram_w_address,
    input  logic                          ram_w_waitrequest,
    output logic [BYTE_ENABLE_WIDTH-1:0]  ram_w_byteenable,
    output logic                          ram_w_write,
    output logic [DATA_WIDTH-1:0]         ram_w_writedata,
    output logic [BURST_WIDTH_W-1:0]      ram_w_burstcount,
    input  logic [DATA_WIDTH-1:0]         data_fifo_out,
    input  logic                          write_fifo_out,
    input  logic                          start_fifo_out,
    input  logic [ADD_WIDTH-1:0]          address_fifo_out,
    input  logic [DATA_WIDTH-1:0]         n_burst_fifo_out,
    output logic                          bussy_fifo_out,
    output logic                          full_fifo_out,
    output logic [FIFO_DEPTH_LOG2:0]      usedw_fifo_out
`ifdef RAM_W_STALL_CNT_EN
    ,
    output logic [DATA_WIDTH-1:0]         stall_cnt_fifo_out
`endif
);

    localparam logic [FIFO_DEPTH_LOG2:0] BURST_WORDS = (FIFO_DEPTH_LOG2 + 1)'(MAX_BURST_COUNT_W);
    localparam logic [BURST_WIDTH_W-1:0] BURST_BEATS = BURST_WIDTH_W'(MAX_BURST_COUNT_W);
    localparam logic [ADD_WIDTH-1:0]     ADDR_STEP   = ADD_WIDTH'(MAX_BURST_COUNT_W * BYTE_ENABLE_WIDTH);

    ram_state_t               state;
    logic [ADD_WIDTH-1:0]     addr_r;
    logic [DATA_WIDTH-1:0]    bursts_left;
    logic [BURST_WIDTH_W-1:0] beats_left;
    logic                     write_r;
    logic                     pop;

    assign pop              = write_r & ~ram_w_waitrequest;
    assign ram_w_write      = write_r;
    assign ram_w_address    = addr_r;
    assign ram_w_byteenable = '1;
    assign ram_w_burstcount = BURST_BEATS;
    assign bussy_fifo_out   = (bursts_left != '0) | (state == BURST);

    ram_w_fifo #(
        .WIDTH      (DATA_WIDTH),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (start_fifo_out),
        .push  (write_fifo_out),
        .pop   (pop),
        .wdata (data_fifo_out),
        .rdata (ram_w_writedata),
        .full  (full_fifo_out),
        .usedw (usedw_fifo_out)
    );

    // A burst only begins once all its beats are buffered, so write never bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr_r      <= '0;
            bursts_left <= '0;
            beats_left  <= '0;
            write_r     <= 1'b0;
        end else if (start_fifo_out) begin
            addr_r      <= address_fifo_out;
            bursts_left <= n_burst_fifo_out;
            beats_left  <= '0;
            write_r     <= 1'b0;
            state       <= (n_burst_fifo_out != '0) ? WAIT_DATA : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    write_r <= 1'b0;
                end
                WAIT_DATA: begin
                    if (usedw_fifo_out >= BURST_WORDS && bursts_left != '0) begin
                        state      <= BURST;
                        beats_left <= BURST_BEATS;
                        write_r    <= 1'b1;
                    end
                end
                BURST: begin
                    if (!ram_w_waitrequest) begin
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BURST_WIDTH_W'(1)) begin
                            addr_r      <= addr_r + ADDR_STEP;
                            bursts_left <= bursts_left - 1'b1;
                            write_r     <= 1'b0;
                            state       <= (bursts_left != DATA_WIDTH'(1)) ? WAIT_DATA : IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    write_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_W_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt_fifo_out <= '0;
        else if (start_fifo_out)
            stall_cnt_fifo_out <= '0;
        else if (write_r && ram_w_waitrequest && stall_cnt_fifo_out != '1)
            stall_cnt_fifo_out <= stall_cnt_fifo_out + 1'b1;
    end
`endif

endmodule

// File: tb/tb_ram_w.sv
// Directed self-checking bench for ram_w: bursts, stalls, overflow, abort,
// zero-burst start and asynchronous reset.
module tb_ram_w;

    logic        clk;
    logic        rst;
    logic [31:0] ram_w_address;
    logic        ram_w_waitrequest;
    logic [3:0]  ram_w_byteenable;
    logic        ram_w_write;
    logic [31:0] ram_w_writedata;
    logic [5:0]  ram_w_burstcount;
    logic [31:0] data_fifo_out;
    logic        write_fifo_out;
    logic        start_fifo_out;
    logic [31:0] address_fifo_out;
    logic [31:0] n_burst_fifo_out;
    logic        bussy_fifo_out;
    logic        full_fifo_out;
    logic [8:0]  usedw_fifo_out;
`ifdef RAM_W_STALL_CNT_EN
    logic [31:0] stall_cnt_fifo_out;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    ram_w dut (
        .clk               (clk),
        .rst               (rst),
        .ram_w_address     (ram_w_address),
        .ram_w_waitrequest (ram_w_waitrequest),
        .ram_w_byteenable  (ram_w_byteenable),
        .ram_w_write       (ram_w_write),
        .ram_w_writedata   (ram_w_writedata),
        .ram_w_burstcount  (ram_w_burstcount),
        .data_fifo_out     (data_fifo_out),
        .write_fifo_out    (write_fifo_out),
        .start_fifo_out    (start_fifo_out),
        .address_fifo_out  (address_fifo_out),
        .n_burst_fifo_out  (n_burst_fifo_out),
        .bussy_fifo_out    (bussy_fifo_out),
        .full_fifo_out     (full_fifo_out),
        .usedw_fifo_out    (usedw_fifo_out)
`ifdef RAM_W_STALL_CNT_EN
        ,
        .stall_cnt_fifo_out (stall_cnt_fifo_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [31:0] addr, input logic [31:0] n);
        start_fifo_out   = 1'b1;
        address_fifo_out = addr;
        n_burst_fifo_out = n;
        step();
        start_fifo_out   = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            data_fifo_out  = first + 32'(i);
            write_fifo_out = 1'b1;
            step();
        end
        write_fifo_out = 1'b0;
    endtask

    // Accepts n_beats beats, checking data/address order, with an optional stall.
    task automatic drain(input int n_beats, input logic [31:0] first, input logic [31:0] base,
                         input int stall_beat, input int stall_len);
        int beat   = 0;
        int stalls = 0;
        int cycles = 0;
        while (beat < n_beats && cycles < 2000) begin
            if (ram_w_write) begin
                check_output("beat_data", ram_w_writedata, first + 32'(beat));
                check_output("beat_addr", ram_w_address, base + 32'((beat / 32) * 128));
                if (beat == stall_beat && stalls < stall_len) begin
                    ram_w_waitrequest = 1'b1;
                    stalls++;
                end else begin
                    ram_w_waitrequest = 1'b0;
                end
                step();
                if (!ram_w_waitrequest)
                    beat++;
            end else begin
                ram_w_waitrequest = 1'b0;
                step();
            end
            cycles++;
        end
        check_output("drain_beats", 64'(beat), 64'(n_beats));
    endtask

    initial begin
        logic seen_write;
        logic seen_bussy;

        rst               = 1'b0;
        ram_w_waitrequest = 1'b0;
        data_fifo_out     = '0;
        write_fifo_out    = 1'b0;
        start_fifo_out    = 1'b0;
        address_fifo_out  = '0;
        n_burst_fifo_out  = '0;

        step();
        step();
        check_output("rst_write", ram_w_write, 0);
        check_output("rst_bussy", bussy_fifo_out, 0);
        check_output("rst_addr",  ram_w_address, 0);
        check_output("rst_full",  full_fifo_out, 0);
        check_output("rst_usedw", usedw_fifo_out, 0);
        rst = 1'b1;
        step();

        $display("[TB] single burst, no stall");
        pulse_start(32'h1000, 1);
        check_output("t1_bussy_start", bussy_fifo_out, 1);
        apply_stimulus(0, 32);
        check_output("t1_usedw32", usedw_fifo_out, 32);
        check_output("t1_write_low", ram_w_write, 0);
        step();
        check_output("t1_write_rise", ram_w_write, 1);
        check_output("t1_burstcount", ram_w_burstcount, 32);
        check_output("t1_byteenable", ram_w_byteenable, 4'hF);
        drain(32, 0, 32'h1000, -1, 0);
        check_output("t1_write_end", ram_w_write, 0);
        check_output("t1_bussy_end", bussy_fifo_out, 0);
        check_output("t1_usedw_end", usedw_fifo_out, 0);

        $display("[TB] two bursts with stall");
        pulse_start(32'h1000, 2);
        ram_w_waitrequest = 1'b1;
        apply_stimulus(100, 64);
        check_output("t2_usedw64", usedw_fifo_out, 64);
        check_output("t2_write_held", ram_w_write, 1);
        drain(64, 100, 32'h1000, 5, 3);
        check_output("t2_write_end", ram_w_write, 0);
        check_output("t2_bussy_end", bussy_fifo_out, 0);
        check_output("t2_addr_next", ram_w_address, 32'h1100);
`ifdef RAM_W_STALL_CNT_EN
        check_output("t2_stall_cnt", stall_cnt_fifo_out, 34);
`endif

        $display("[TB] overflow");
        pulse_start(32'h0, 0);
        ram_w_waitrequest = 1'b1;
        apply_stimulus(0, 256);
        check_output("t3_full", full_fifo_out, 1);
        check_output("t3_usedw256", usedw_fifo_out, 256);
        apply_stimulus(256, 4);
        check_output("t3_full_after", full_fifo_out, 1);
        check_output("t3_usedw_after", usedw_fifo_out, 256);
        check_output("t3_head", ram_w_writedata, 0);
        check_output("t3_write", ram_w_write, 0);
        check_output("t3_bussy", bussy_fifo_out, 0);

        $display("[TB] abort mid-burst");
        pulse_start(32'h1000, 1);
        check_output("t4_usedw_clr", usedw_fifo_out, 0);
        ram_w_waitrequest = 1'b1;
        apply_stimulus(200, 32);
        drain(10, 200, 32'h1000, -1, 0);
        check_output("t4_beat10", ram_w_writedata, 210);
        pulse_start(32'h2000, 1);
        check_output("t4_write_drop", ram_w_write, 0);
        check_output("t4_usedw_abort", usedw_fifo_out, 0);
        check_output("t4_bussy", bussy_fifo_out, 1);
        check_output("t4_addr", ram_w_address, 32'h2000);
        ram_w_waitrequest = 1'b1;
        apply_stimulus(300, 32);
        drain(32, 300, 32'h2000, -1, 0);
        check_output("t4_bussy_end", bussy_fifo_out, 0);
        check_output("t4_addr_next", ram_w_address, 32'h2080);

        $display("[TB] zero bursts");
        pulse_start(32'h4000, 0);
        seen_write = 1'b0;
        seen_bussy = 1'b0;
        for (int i = 0; i < 45; i++) begin
            data_fifo_out  = 32'(i);
            write_fifo_out = (i < 40);
            step();
            seen_write |= ram_w_write;
            seen_bussy |= bussy_fifo_out;
        end
        write_fifo_out = 1'b0;
        check_output("t5_no_write", seen_write, 0);
        check_output("t5_no_bussy", seen_bussy, 0);
        check_output("t5_usedw", usedw_fifo_out, 40);

        $display("[TB] async reset mid-burst");
        pulse_start(32'h3000, 1);
        ram_w_waitrequest = 1'b1;
        apply_stimulus(400, 32);
        drain(3, 400, 32'h3000, -1, 0);
        check_output("t6_write_pre", ram_w_write, 1);
        #2;
        rst = 1'b0;
        #1;
        check_output("t6_write", ram_w_write, 0);
        check_output("t6_bussy", bussy_fifo_out, 0);
        check_output("t6_addr", ram_w_address, 0);
        check_output("t6_usedw", usedw_fifo_out, 0);
`ifdef RAM_W_STALL_CNT_EN
        check_output("t6_stall_cnt", stall_cnt_fifo_out, 0);
`endif
        #2;
        rst = 1'b1;
        step();
        check_output("t6_idle_after", ram_w_write, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
